iob_cache_front_end_fifo: RTL and testbench

//  Buffered successor to the cache front-end: accepts IOb requests into a DEPTH-entry request FIFO,

---
 rtl/iob_cache_front_end_fifo.sv | 164 ++++++++++++++++
 tb/tb_iob_cache_front_end_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_front_end_fifo.sv
// Buffered IOb cache front-end: request FIFO, data/CSR path decode, in-order registered responses.
// Optional performance counters are compiled in when IOB_CACHE_FE_PERF_EN is defined.
module iob_cache_front_end_fifo #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int USE_CTRL    = 0,
  parameter int CSRS_ADDR_W = 5
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_i,
`ifdef IOB_CACHE_FE_PERF_EN
  input  logic                       perf_clr_i,
  output logic [31:0]                acc_cnt_o,
  output logic [31:0]                stall_cnt_o,
`endif
  input  logic                       iob_valid_i,
  input  logic [ADDR_W-1:0]          iob_addr_i,
  input  logic [DATA_W-1:0]          iob_wdata_i,
  input  logic [DATA_W/8-1:0]        iob_wstrb_i,
  output logic                       iob_ready_o,
  output logic                       iob_rvalid_o,
  output logic [DATA_W-1:0]          iob_rdata_o,
  output logic                       data_req_o,
  output logic [ADDR_W-USE_CTRL-1:0] data_addr_o,
  output logic [DATA_W-1:0]          data_wdata_o,
  output logic [DATA_W/8-1:0]        data_wstrb_o,
  input  logic [DATA_W-1:0]          data_rdata_i,
  input  logic                       data_ack_i,
  output logic                       ctrl_req_o,
  output logic [CSRS_ADDR_W-1:0]     ctrl_addr_o,
  input  logic [DATA_W-1:0]          ctrl_rdata_i,
  input  logic                       ctrl_ack_i
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STRB_W  = DATA_W / 8;
  localparam int DADDR_W = ADDR_W - USE_CTRL;

  // Entry storage (no reset needed: contents are only observed while count_q != 0)
  logic               ent_ctrl_q  [DEPTH];
  logic [DADDR_W-1:0] ent_addr_q  [DEPTH];
  logic [DATA_W-1:0]  ent_wdata_q [DEPTH];
  logic [STRB_W-1:0]  ent_wstrb_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              push_ctrl;
  logic              head_ctrl;
  logic              head_read;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = iob_valid_i & ~full;
  assign push_ctrl = (USE_CTRL != 0) && iob_addr_i[ADDR_W-1];

  assign head_ctrl = ent_ctrl_q[rd_ptr_q];
  assign head_read = (ent_wstrb_q[rd_ptr_q] == '0);

  assign data_req_o   = ~empty & ~head_ctrl;
  assign ctrl_req_o   = ~empty &  head_ctrl;
  assign data_addr_o  = ent_addr_q[rd_ptr_q];
  assign data_wdata_o = ent_wdata_q[rd_ptr_q];
  assign data_wstrb_o = ent_wstrb_q[rd_ptr_q];
  assign ctrl_addr_o  = ent_addr_q[rd_ptr_q][CSRS_ADDR_W-1:0];

  // Acks on the path that is not currently requesting are ignored
  assign pop = (data_req_o & data_ack_i) | (ctrl_req_o & ctrl_ack_i);

  assign iob_ready_o  = ~full;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop && head_read) begin
      rvalid_d = 1'b1;
      rdata_d  = head_ctrl ? ctrl_rdata_i : data_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && cke_i && push) begin
      ent_ctrl_q[wr_ptr_q]  <= push_ctrl;
      ent_addr_q[wr_ptr_q]  <= iob_addr_i[DADDR_W-1:0];
      ent_wdata_q[wr_ptr_q] <= iob_wdata_i;
      ent_wstrb_q[wr_ptr_q] <= iob_wstrb_i;
    end
  end

`ifdef IOB_CACHE_FE_PERF_EN
  logic [31:0] acc_cnt_q,   acc_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters; a clear request overrides any same-cycle increment
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (perf_clr_i) begin
      acc_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (push && (acc_cnt_q != '1))
        acc_cnt_d = acc_cnt_q + 32'd1;
      if (iob_valid_i && full && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (cke_i) begin
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign acc_cnt_o   = acc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iob_cache_front_end_fifo.sv
// Bench for iob_cache_front_end_fifo: directed scenarios plus random traffic against a queue model.
module tb_iob_cache_front_end_fifo;

  localparam int DEPTH = 4;

  typedef struct {
    logic        ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        cke, rst;
  logic        iob_valid;
  logic [31:0] iob_addr, iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready_o, iob_rvalid_o;
  logic [31:0] iob_rdata_o;
  logic        data_req_o;
  logic [30:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        ctrl_req_o;
  logic [4:0]  ctrl_addr_o;
  logic [31:0] ctrl_rdata;
  logic        ctrl_ack;
`ifdef IOB_CACHE_FE_PERF_EN
  logic        perf_clr = 1'b0;
  logic        pc_next  = 1'b0;
  logic [31:0] acc_cnt_o, stall_cnt_o;
  logic [31:0] m_acc, m_stall;
`endif

  req_t        mq[$];
  logic        m_rvalid;
  logic [31:0] m_rdata;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  iob_cache_front_end_fifo #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .USE_CTRL(1), .CSRS_ADDR_W(5)
  ) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
`ifdef IOB_CACHE_FE_PERF_EN
    .perf_clr_i(perf_clr), .acc_cnt_o(acc_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
    .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o(iob_rdata_o), .data_req_o(data_req_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_wstrb_o(data_wstrb_o), .data_rdata_i(data_rdata),
    .data_ack_i(data_ack), .ctrl_req_o(ctrl_req_o), .ctrl_addr_o(ctrl_addr_o),
    .ctrl_rdata_i(ctrl_rdata), .ctrl_ack_i(ctrl_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    check("ready", iob_ready_o, (mq.size() != DEPTH));
    check("rvalid", iob_rvalid_o, m_rvalid);
    check("rdata", iob_rdata_o, m_rdata);
    if (mq.size() != 0) begin
      if (mq[0].ctrl) begin
        check("data_req", data_req_o, 1'b0);
        check("ctrl_req", ctrl_req_o, 1'b1);
        check("ctrl_addr", ctrl_addr_o, mq[0].addr[4:0]);
      end else begin
        check("data_req", data_req_o, 1'b1);
        check("ctrl_req", ctrl_req_o, 1'b0);
        check("data_addr", data_addr_o, mq[0].addr[30:0]);
        check("data_wdata", data_wdata_o, mq[0].wdata);
        check("data_wstrb", data_wstrb_o, mq[0].wstrb);
      end
    end else begin
      check("data_req_empty", data_req_o, 1'b0);
      check("ctrl_req_empty", ctrl_req_o, 1'b0);
    end
`ifdef IOB_CACHE_FE_PERF_EN
    check("acc_cnt", acc_cnt_o, m_acc);
    check("stall_cnt", stall_cnt_o, m_stall);
`endif
  endtask

  // One clock cycle: check current outputs, drive inputs for the next edge, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic dack, input logic [31:0] drd,
                      input logic cack, input logic [31:0] crd, input logic ck, input logic rs);
    req_t h, e;
    logic acc_ok;
    @(negedge clk);
    compare_outputs();
    iob_valid = v; iob_addr = a; iob_wdata = wd; iob_wstrb = ws;
    data_ack = dack; data_rdata = drd; ctrl_ack = cack; ctrl_rdata = crd;
    cke = ck; rst = rs;
`ifdef IOB_CACHE_FE_PERF_EN
    perf_clr = pc_next;
`endif
    if (rs) begin
      mq.delete();
      m_rvalid = 1'b0;
      m_rdata  = '0;
`ifdef IOB_CACHE_FE_PERF_EN
      m_acc = '0; m_stall = '0;
`endif
    end else if (ck) begin
      acc_ok = v && (mq.size() < DEPTH);
`ifdef IOB_CACHE_FE_PERF_EN
      if (perf_clr) begin
        m_acc = '0; m_stall = '0;
      end else begin
        if (acc_ok && m_acc != 32'hFFFF_FFFF) m_acc++;
        if (v && mq.size() == DEPTH && m_stall != 32'hFFFF_FFFF) m_stall++;
      end
`endif
      m_rvalid = 1'b0;
      if (mq.size() != 0) begin
        h = mq[0];
        if (h.ctrl ? cack : dack) begin
          void'(mq.pop_front());
          if (h.wstrb == 4'h0) begin
            m_rvalid = 1'b1;
            m_rdata  = h.ctrl ? crd : drd;
          end
        end
      end
      if (acc_ok) begin
        e.ctrl = a[31]; e.addr = a; e.wdata = wd; e.wstrb = ws;
        mq.push_back(e);
      end
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    step(1'b1, a, wd, ws, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    cke = 1'b1; rst = 1'b1; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
    data_ack = 1'b0; data_rdata = '0; ctrl_ack = 1'b0; ctrl_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_rvalid = 1'b0; m_rdata = '0;
`ifdef IOB_CACHE_FE_PERF_EN
    m_acc = '0; m_stall = '0;
`endif
    check("rst_ready", iob_ready_o, 1'b1);
    check("rst_data_req", data_req_o, 1'b0);
    check("rst_ctrl_req", ctrl_req_o, 1'b0);
    check("rst_rvalid", iob_rvalid_o, 1'b0);
    check("rst_rdata", iob_rdata_o, 32'h0);

    // Fill to full with data reads while no ack arrives, then drain one per cycle
    for (int unsigned i = 0; i < 5; i++) push_req(32'h100 + 32'(i * 4), 32'(i), 4'h0);
    settle();
    check("full_ready", iob_ready_o, 1'b0);
    check("full_head_addr", data_addr_o, 31'h100);
    step(1'b0, '0, '0, '0, 1'b1, 32'hD000, 1'b0, '0, 1'b1, 1'b0);
    settle();
    check("drain_first_rvalid", iob_rvalid_o, 1'b1);
    check("drain_first_rdata", iob_rdata_o, 32'hD000);
    for (int unsigned i = 1; i < 5; i++)
      step(1'b0, '0, '0, '0, 1'b1, 32'hD000 + 32'(i), 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Mixed data write, CSR read, data read
    push_req(32'h0000_0010, 32'h1111_2222, 4'hF);
    push_req(32'h8000_0004, '0, 4'h0);
    push_req(32'h0000_0020, '0, 4'h0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h5555, 1'b0, '0, 1'b1, 1'b0);
    settle();
    check("wr_no_rvalid", iob_rvalid_o, 1'b0);
    check("csr_req", ctrl_req_o, 1'b1);
    check("csr_addr", ctrl_addr_o, 5'd4);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'hCAFE, 1'b1, 1'b0);
    settle();
    check("csr_rvalid", iob_rvalid_o, 1'b1);
    check("csr_rdata", iob_rdata_o, 32'hCAFE);
    check("after_csr_addr", data_addr_o, 31'h20);
    step(1'b0, '0, '0, '0, 1'b1, 32'hBEEF, 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Spurious CSR ack with a data head
    push_req(32'h40, '0, 4'h0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'h123, 1'b1, 1'b0);
    settle();
    check("spur_req_held", data_req_o, 1'b1);
    check("spur_no_rvalid", iob_rvalid_o, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h777, 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Reset with pending entries and an ack on the head
    push_req(32'h50, '0, 4'h0);
    push_req(32'h54, '0, 4'h0);
    push_req(32'h58, '0, 4'h0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h999, 1'b0, '0, 1'b1, 1'b1);
    settle();
    check("rst_mid_req", data_req_o, 1'b0);
    check("rst_mid_ready", iob_ready_o, 1'b1);
    check("rst_mid_rvalid", iob_rvalid_o, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 32'h888, 1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom_range(9) < 6), $urandom, $urandom, ws,
           ($urandom_range(9) < 4), $urandom, ($urandom_range(9) < 4), $urandom,
           ($urandom_range(9) != 0), ($urandom_range(199) == 0));
    end
    step(1'b0, '0, '0, '0, 1'b1, '0, 1'b1, '0, 1'b1, 1'b0);
    idle(DEPTH * 2);

`ifdef IOB_CACHE_FE_PERF_EN
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 4; i++) push_req(32'h200 + 32'(i * 4), '0, 4'h0);
    for (int unsigned i = 0; i < 3; i++) push_req(32'h300, '0, 4'h0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, 32'(i), 1'b0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 6; i++)
      step(1'b1, 32'h400 + 32'(i * 4), '0, 4'h0, 1'b1, 32'(i), 1'b0, '0, 1'b1, 1'b0);
    settle();
    check("perf_acc", acc_cnt_o, 32'd10);
    check("perf_stall", stall_cnt_o, 32'd3);
    pc_next = 1'b1;
    idle(1);
    pc_next = 1'b0;
    settle();
    check("perf_clr_acc", acc_cnt_o, 32'd0);
    check("perf_clr_stall", stall_cnt_o, 32'd0);
    idle(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
